rr_arbiter_mux: RTL and testbench

- Registered, handshaked N-to-1 multiplexer: the next generation of the combinational channel mux.
- Instead of an external select, it arbitrates among N valid/ready source channels of M bits each.
- Forwards one word per cycle into a single output register, with round-robin or fixed-priority selection.
- Sits between multiple producers (e.g. memory/IO request sources) and one shared consumer in the pipeline.

---
 rtl/rr_arbiter_mux.sv | 93 +++++++++
 tb/tb_rr_arbiter_mux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_mux.sv
// Registered N-to-1 valid/ready arbiter-mux: round-robin (MODE=0) or fixed
// lowest-index priority (MODE=1) selection into a single output register.
module rr_arbiter_mux #(
  parameter int N    = 4,
  parameter int M    = 8,
  parameter int MODE = 0,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          in_valid_i,
  input  logic [N-1:0][M-1:0]   in_data_i,
  output logic [N-1:0]          in_ready_o,
  output logic                  out_valid_o,
  output logic [M-1:0]          out_data_o,
  output logic [SEL_W-1:0]      out_sel_o,
  input  logic                  out_ready_i
);

  // Handshake: a word moves on a port at a rising edge where valid & ready are
  // both high; valid must not wait on ready, and in_ready never looks at the
  // in_valid of its own channel except through the grant search.
  logic              out_valid_q, out_valid_d;
  logic [M-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load;
  logic              grant_found;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W:0]    idx;
  logic [SEL_W-1:0]  ptr_inc;

  assign load = ~out_valid_q | out_ready_i;

  // Search starts at ptr and wraps modulo N; in MODE=1 ptr stays 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
      if (!grant_found && in_valid_i[idx[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_o[i] = load & grant_found & ~rst & (grant_idx == SEL_W'(i));
    end
  end

  assign ptr_inc = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = in_data_i[grant_idx];
        out_sel_d  = grant_idx;
        if (MODE == 0) ptr_d = ptr_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Bench for rr_arbiter_mux: three instances (N=4 round-robin, N=4 fixed
// priority, N=3 round-robin) driven by directed vectors, checked by a scoreboard.
module tb_rr_arbiter_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: N=4 MODE=0
  logic [3:0]      a_vld, a_rdy;
  logic [3:0][7:0] a_dat;
  logic            a_ov, a_ordy;
  logic [7:0]      a_od;
  logic [1:0]      a_os;
  // instance b: N=4 MODE=1
  logic [3:0]      b_vld, b_rdy;
  logic [3:0][7:0] b_dat;
  logic            b_ov, b_ordy;
  logic [7:0]      b_od;
  logic [1:0]      b_os;
  // instance c: N=3 MODE=0
  logic [2:0]      c_vld, c_rdy;
  logic [2:0][7:0] c_dat;
  logic            c_ov, c_ordy;
  logic [7:0]      c_od;
  logic [1:0]      c_os;

  rr_arbiter_mux #(.N(4), .M(8), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_valid_i(a_vld), .in_data_i(a_dat), .in_ready_o(a_rdy),
    .out_valid_o(a_ov), .out_data_o(a_od), .out_sel_o(a_os), .out_ready_i(a_ordy));
  rr_arbiter_mux #(.N(4), .M(8), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(b_vld), .in_data_i(b_dat), .in_ready_o(b_rdy),
    .out_valid_o(b_ov), .out_data_o(b_od), .out_sel_o(b_os), .out_ready_i(b_ordy));
  rr_arbiter_mux #(.N(3), .M(8), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid_i(c_vld), .in_data_i(c_dat), .in_ready_o(c_rdy),
    .out_valid_o(c_ov), .out_data_o(c_od), .out_sel_o(c_os), .out_ready_i(c_ordy));

  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] exp_c[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop the oldest expected {sel,data} for instance d and compare.
  task automatic mon(input int d, input logic [9:0] got);
    logic [9:0] e;
    int sz;
    sz = (d == 0) ? exp_a.size() : (d == 1) ? exp_b.size() : exp_c.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL out_word_%0d: got 0x%0h with nothing expected", d, got);
    end else begin
      case (d)
        0:       e = exp_a.pop_front();
        1:       e = exp_b.pop_front();
        default: e = exp_c.pop_front();
      endcase
      chk($sformatf("out_word_%0d", d), 32'(got), 32'(e));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (a_ov && a_ordy) mon(0, {a_os, a_od});
        if (b_ov && b_ordy) mon(1, {b_os, b_od});
        if (c_ov && c_ordy) mon(2, {c_os, c_od});
      end
    end
  end

  // One cycle: apply inputs at posedge+1, check in_ready at the negedge,
  // return at the following posedge+1.
  task automatic drive(input int d, input logic [3:0] v, input logic r,
                       input logic [3:0] er, input logic push, input logic [9:0] w);
    case (d)
      0: begin a_vld = v; a_ordy = r; if (push) exp_a.push_back(w); end
      1: begin b_vld = v; b_ordy = r; if (push) exp_b.push_back(w); end
      default: begin c_vld = v[2:0]; c_ordy = r; if (push) exp_c.push_back(w); end
    endcase
    @(negedge clk);
    case (d)
      0:       chk("in_ready_a", 32'(a_rdy), 32'(er));
      1:       chk("in_ready_b", 32'(b_rdy), 32'(er));
      default: chk("in_ready_c", 32'(c_rdy), 32'(er[2:0]));
    endcase
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rot_sel[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] rot_dat[8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h11, 8'h22, 8'h33};
  logic [3:0] rot_rdy[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [2:0] c_rdy_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [1:0] c_sel_tab[6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [7:0] c_dat_tab[6] = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h11, 8'h22};

  initial begin
    rst = 1'b1;
    a_vld = '0; a_dat = '0; a_ordy = 1'b0;
    b_vld = '0; b_dat = {8'h33, 8'h22, 8'h11, 8'h00}; b_ordy = 1'b0;
    c_vld = '0; c_dat = {8'h22, 8'h11, 8'h00}; c_ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(a_ov), 32'd0);
    chk("rst_out_sel", 32'(a_os), 32'd0);

    // load 0xAB, then assert reset between edges
    a_vld = 4'b0001; a_dat[0] = 8'hAB; a_ordy = 1'b0;
    @(posedge clk);
    #1;
    chk("load_ab_valid", 32'(a_ov), 32'd1);
    chk("load_ab_data", 32'(a_od), 32'hAB);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(a_ov), 32'd0);
    chk("async_rst_data", 32'(a_od), 32'd0);
    chk("async_rst_sel", 32'(a_os), 32'd0);
    chk("async_rst_in_ready", 32'(a_rdy), 32'd0);
    a_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_dat = {8'h33, 8'h22, 8'h11, 8'h00};

    // round-robin rotation
    for (int i = 0; i < 8; i++) drive(0, 4'b1111, 1'b1, rot_rdy[i], 1'b1, {rot_sel[i], rot_dat[i]});
    drive(0, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'd0);

    // sparse requests and pointer wrap
    drive(0, 4'b0100, 1'b1, 4'b0100, 1'b1, {2'd2, 8'h22});
    drive(0, 4'b0101, 1'b1, 4'b0001, 1'b1, {2'd0, 8'h00});
    drive(0, 4'b0101, 1'b1, 4'b0100, 1'b1, {2'd2, 8'h22});
    drive(0, 4'b0010, 1'b1, 4'b0010, 1'b1, {2'd1, 8'h11});

    // back-pressure holding 0x11
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b1111, 1'b0, 4'b0000, 1'b0, 10'd0);
      chk("hold_valid", 32'(a_ov), 32'd1);
      chk("hold_data", 32'(a_od), 32'h11);
      chk("hold_sel", 32'(a_os), 32'd1);
    end
    drive(0, 4'b1111, 1'b1, 4'b0100, 1'b1, {2'd2, 8'h22});
    chk("no_bubble_valid", 32'(a_ov), 32'd1);
    chk("no_bubble_sel", 32'(a_os), 32'd2);
    drive(0, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'd0);
    chk("drained_valid", 32'(a_ov), 32'd0);

    // fixed priority
    for (int i = 0; i < 5; i++) drive(1, 4'b1110, 1'b1, 4'b0010, 1'b1, {2'd1, 8'h11});
    drive(1, 4'b1111, 1'b1, 4'b0001, 1'b1, {2'd0, 8'h00});
    drive(1, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'd0);

    // N=3 wrap modulo 3
    for (int i = 0; i < 6; i++)
      drive(2, 4'b0111, 1'b1, {1'b0, c_rdy_tab[i]}, 1'b1, {c_sel_tab[i], c_dat_tab[i]});
    drive(2, 4'b0000, 1'b1, 4'b0000, 1'b0, 10'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("leftover_a", 32'(exp_a.size()), 32'd0);
    chk("leftover_b", 32'(exp_b.size()), 32'd0);
    chk("leftover_c", 32'(exp_c.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
